// File: rtl/data_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_pkg                                                 |
// | Description : Shared types and helpers for the load/store data memory.     |
// |               size_e   - access size encoding (byte/half/word/dword)        |
// |               state_e  - controller states                                  |
// |               lane_mask - byte-enable mask for an access                    |
// |               extend    - sign/zero extension of raw load data              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte enables for an access of (1 << sz) bytes starting at lane 'off'.
    // Computed in a 64-bit-word frame; narrower memories use the low lanes.
    function automatic logic [7:0] lane_mask(input size_e sz, input logic [2:0] off);
        logic [15:0] w_m;
        w_m = ((16'd1 << (5'd1 << sz)) - 16'd1) << off;
        return w_m[7:0];
    endfunction

    // Extend the low (1 << sz) bytes of 'raw' from their top bit.
    // A dword already fills 64 bits, so 'uns' has no effect there.
    function automatic logic [63:0] extend(input logic [63:0] raw, input size_e sz,
                                           input logic uns);
        logic [63:0] w_r;
        case (sz)
            SZ_B:    w_r = {{56{~uns & raw[7]}},  raw[7:0]};
            SZ_H:    w_r = {{48{~uns & raw[15]}}, raw[15:0]};
            SZ_W:    w_r = {{32{~uns & raw[31]}}, raw[31:0]};
            default: w_r = raw;
        endcase
        return w_r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_lane_align                                          |
// | Description : Purely combinational lane steering for the data memory.      |
// |               Store side: shifts right-aligned write data into its byte    |
// |               lanes and builds the byte-enable mask.                       |
// |               Load side: extracts the addressed bytes from a memory word   |
// |               and sign/zero extends them.                                  |
// |               Also flags accesses whose offset is not size-aligned.        |
// | Ports       : i_size      access size                                      |
// |               i_offset    byte lane offset within the word                 |
// |               i_unsigned  zero-extend loads when 1                         |
// |               i_wdata     right-aligned store data                         |
// |               i_rword     memory word being read                           |
// |               o_st_data   lane-shifted store data                          |
// |               o_st_mask   byte enables for the store                       |
// |               o_ld_data   extended load result                             |
// |               o_misaligned offset/size combination is illegal              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_lane_align
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  size_e                           i_size,
    input  logic [$clog2(DATA_W/8)-1:0]     i_offset,
    input  logic                            i_unsigned,
    input  logic [DATA_W-1:0]               i_wdata,
    input  logic [DATA_W-1:0]               i_rword,
    output logic [DATA_W-1:0]               o_st_data,
    output logic [DATA_W/8-1:0]             o_st_mask,
    output logic [DATA_W-1:0]               o_ld_data,
    output logic                            o_misaligned
);

    localparam int c_LANES = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_LANES);

    logic [c_OFF_W+2:0] w_shamt;
    logic [7:0]         w_mask8;
    logic [7:0]         w_align;
    logic [63:0]        w_raw;
    logic [63:0]        w_ext;

    // Bit shift equivalent of the byte offset.
    assign w_shamt   = {i_offset, 3'b000};

    assign o_st_data = i_wdata << w_shamt;
    assign w_mask8   = lane_mask(i_size, 3'(i_offset));
    assign o_st_mask = w_mask8[c_LANES-1:0];

    assign w_raw     = 64'(i_rword >> w_shamt);
    assign w_ext     = extend(w_raw, i_size, i_unsigned);
    assign o_ld_data = w_ext[DATA_W-1:0];

    // Offset must be a multiple of the access size; a dword cannot fit a
    // 32-bit word at all.
    assign w_align      = 8'((8'd1 << i_size) - 8'd1);
    assign o_misaligned = (|(8'(i_offset) & w_align)) ||
                          ((DATA_W == 32) && (i_size == SZ_D));

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_lsu                                                 |
// | Description : Byte-addressable data memory for the load/store stage.       |
// |               Valid/ready request channel, registered response channel,    |
// |               byte/half/word/dword accesses with sign/zero extension,      |
// |               misalignment and range error reporting, and a hardware       |
// |               clear of the whole array after every reset.                  |
// | Ports       : clk, rst         clock and synchronous active-high reset     |
// |               req_*            request channel (valid/ready handshake)     |
// |               rsp_*            response channel (valid/ready handshake)    |
// |               init_busy        array clear in progress                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_busy
);

    localparam int c_LANES  = DATA_W / 8;
    localparam int c_OFF_W  = $clog2(c_LANES);
    localparam int c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_WIDX_W = ADDR_W - c_OFF_W;
    localparam logic [c_WIDX_W-1:0] c_DEPTH_IDX = c_WIDX_W'(DEPTH);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(DEPTH - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [c_IDX_W-1:0]   r_init_cnt;
    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_rsp_err;

    size_e                w_size;
    logic [c_WIDX_W-1:0]  w_word_idx;
    logic [c_OFF_W-1:0]   w_offset;
    logic [c_IDX_W-1:0]   w_mem_idx;
    logic [DATA_W-1:0]    w_rword;
    logic [DATA_W-1:0]    w_st_data;
    logic [c_LANES-1:0]   w_st_mask;
    logic [DATA_W-1:0]    w_ld_data;
    logic                 w_misaligned;
    logic                 w_out_of_range;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_wr_en;

    // ------------------------------------------------------------------
    // Address decode and lane steering
    // ------------------------------------------------------------------
    assign w_size         = size_e'(req_size);
    assign w_word_idx     = req_addr[ADDR_W-1:c_OFF_W];
    assign w_offset       = req_addr[c_OFF_W-1:0];
    assign w_mem_idx      = w_word_idx[c_IDX_W-1:0];
    assign w_out_of_range = (w_word_idx >= c_DEPTH_IDX);
    assign w_err          = w_misaligned || w_out_of_range;
    assign w_rword        = r_mem[w_mem_idx];

    data_mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .i_size       (w_size),
        .i_offset     (w_offset),
        .i_unsigned   (req_unsigned),
        .i_wdata      (req_wdata),
        .i_rword      (w_rword),
        .o_st_data    (w_st_data),
        .o_st_mask    (w_st_mask),
        .o_ld_data    (w_ld_data),
        .o_misaligned (w_misaligned)
    );

    assign w_accept = req_valid && req_ready;
    assign w_wr_en  = w_accept && req_we && !w_err;

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Controller: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT: begin
                // Last clear write and the move to IDLE share one edge, so
                // the clear takes exactly DEPTH cycles.
                if (r_init_cnt == c_LAST_IDX) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = w_accept ? RESP : IDLE;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Controller: outputs
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        init_busy = 1'b0;
        case (r_state)
            INIT: init_busy = 1'b1;
            IDLE: req_ready = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                // A new request may only enter as the current response leaves.
                req_ready = rsp_ready;
            end
            default: init_busy = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Clear counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= r_init_cnt + c_IDX_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Storage array: clear writes during INIT, byte-masked stores otherwise.
    // Writes land on the acceptance edge, so a load accepted on the next
    // cycle already sees the new bytes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == INIT) begin
                r_mem[r_init_cnt] <= '0;
            end else if (w_wr_en) begin
                for (int b = 0; b < c_LANES; b++) begin
                    if (w_st_mask[b]) begin
                        r_mem[w_mem_idx][8*b +: 8] <= w_st_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers: only updated on acceptance, so data and error
    // stay put while the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || req_we) ? '0 : w_ld_data;
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
